mod_phase_sequencer: RTL and testbench

// Frame-level sequencer for the nonoverlapping modulation clock generator.
// - Each frame steps PHASE_SEL through NUM_PHASES phase offsets.
// - Each phase is one drain -> expose -> readout cycle.
// - It drives the generator's DRAIN_B and PHASE_SEL/DUTY_SEL inputs.
// - It handshakes with the readout path.
// - Sits between the host configuration registers and the clkgen/pixel array.

---
 rtl/mod_phase_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mod_phase_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_phase_sequencer.sv
// Frame sequencer for the nonoverlapping modulation clock generator.
// Steps PHASE_SEL through NUM_PHASES drain/expose/readout cycles per frame.
module mod_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int PHASE_STEP = 8,
    parameter int DRAIN_LEN  = 16,
    parameter int EXPO_W     = 16
) (
    input  logic              CLK_IN,
    input  logic              RESET_B,
    input  logic              START,
    input  logic              ABORT,
    input  logic [EXPO_W-1:0] EXPO_CYCLES,
    input  logic [4:0]        PHASE_OFFSET,
    input  logic [3:0]        DUTY_CFG,
    input  logic              READOUT_ACK,
    output logic              DRAIN_B,
    output logic [4:0]        PHASE_SEL,
    output logic [3:0]        DUTY_SEL,
    output logic              EXPOSING,
    output logic              READOUT_REQ,
    output logic [1:0]        PHASE_IDX,
    output logic              BUSY,
    output logic              FRAME_DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_EXPOSE,
        S_READOUT
    } state_t;

    localparam int                DW         = $clog2(DRAIN_LEN);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_LEN - 1);
    localparam logic [EXPO_W-1:0] EXPO_ONE   = EXPO_W'(1);
    localparam logic [4:0]        STEP       = 5'(PHASE_STEP);

    state_t              state_q, state_d;
    logic [DW-1:0]       drn_cnt_q, drn_cnt_d;
    logic [4:0]          sub_q, sub_d;
    logic [EXPO_W-1:0]   per_q, per_d;
    logic [EXPO_W-1:0]   expo_q, expo_d;
    logic                drain_b_q, drain_b_d;
    logic [4:0]          phase_sel_q, phase_sel_d;
    logic [3:0]          duty_sel_q, duty_sel_d;
    logic                exposing_q, exposing_d;
    logic                req_q, req_d;
    logic [1:0]          idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State, counters and registered outputs.
    always_ff @(posedge CLK_IN or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q     <= S_IDLE;
            drn_cnt_q   <= '0;
            sub_q       <= '0;
            per_q       <= '0;
            expo_q      <= EXPO_ONE;
            drain_b_q   <= 1'b0;
            phase_sel_q <= '0;
            duty_sel_q  <= '0;
            exposing_q  <= 1'b0;
            req_q       <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drn_cnt_q   <= drn_cnt_d;
            sub_q       <= sub_d;
            per_q       <= per_d;
            expo_q      <= expo_d;
            drain_b_q   <= drain_b_d;
            phase_sel_q <= phase_sel_d;
            duty_sel_q  <= duty_sel_d;
            exposing_q  <= exposing_d;
            req_q       <= req_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state and next registered outputs; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        drn_cnt_d   = drn_cnt_q;
        sub_d       = sub_q;
        per_d       = per_q;
        expo_d      = expo_q;
        drain_b_d   = drain_b_q;
        phase_sel_d = phase_sel_q;
        duty_sel_d  = duty_sel_q;
        exposing_d  = exposing_q;
        req_d       = req_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (ABORT) begin
            state_d    = S_IDLE;
            drain_b_d  = 1'b0;
            exposing_d = 1'b0;
            req_d      = 1'b0;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    drain_b_d  = 1'b0;
                    exposing_d = 1'b0;
                    req_d      = 1'b0;
                    busy_d     = 1'b0;
                    // done_q marks the FRAME_DONE cycle: no restart there
                    if (START && !done_q) begin
                        expo_d      = (EXPO_CYCLES == '0) ? EXPO_ONE
                                                          : EXPO_CYCLES;
                        idx_d       = '0;
                        phase_sel_d = PHASE_OFFSET;
                        duty_sel_d  = DUTY_CFG;
                        drn_cnt_d   = '0;
                        busy_d      = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drn_cnt_q == DRAIN_LAST) begin
                        drain_b_d  = 1'b1;
                        exposing_d = 1'b1;
                        sub_d      = '0;
                        per_d      = '0;
                        state_d    = S_EXPOSE;
                    end else begin
                        drn_cnt_d = drn_cnt_q + 1'b1;
                    end
                end
                S_EXPOSE: begin
                    if (sub_q == 5'd31 && per_q == expo_q - EXPO_ONE) begin
                        exposing_d = 1'b0;
                        req_d      = 1'b1;
                        state_d    = S_READOUT;
                    end else begin
                        sub_d = sub_q + 1'b1;
                        if (sub_q == 5'd31) begin
                            per_d = per_q + EXPO_ONE;
                        end
                    end
                end
                S_READOUT: begin
                    if (READOUT_ACK) begin
                        req_d     = 1'b0;
                        drain_b_d = 1'b0;
                        if (int'(idx_q) < NUM_PHASES - 1) begin
                            idx_d       = idx_q + 1'b1;
                            phase_sel_d = phase_sel_q + STEP;
                            drn_cnt_d   = '0;
                            state_d     = S_DRAIN;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign DRAIN_B     = drain_b_q;
    assign PHASE_SEL   = phase_sel_q;
    assign DUTY_SEL    = duty_sel_q;
    assign EXPOSING    = exposing_q;
    assign READOUT_REQ = req_q;
    assign PHASE_IDX   = idx_q;
    assign BUSY        = busy_q;
    assign FRAME_DONE  = done_q;

endmodule

// File: tb/tb_mod_phase_sequencer.sv
// Testbench for mod_phase_sequencer.
// Scoreboard of expected phase records and frame completions.
module tb_mod_phase_sequencer;

    logic        CLK_IN = 1'b0;
    logic        RESET_B = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [15:0] EXPO_CYCLES = '0;
    logic [4:0]  PHASE_OFFSET = '0;
    logic [3:0]  DUTY_CFG = '0;
    logic        READOUT_ACK = 1'b0;
    logic        DRAIN_B;
    logic [4:0]  PHASE_SEL;
    logic [3:0]  DUTY_SEL;
    logic        EXPOSING;
    logic        READOUT_REQ;
    logic [1:0]  PHASE_IDX;
    logic        BUSY;
    logic        FRAME_DONE;

    mod_phase_sequencer dut (
        .CLK_IN      (CLK_IN),
        .RESET_B     (RESET_B),
        .START       (START),
        .ABORT       (ABORT),
        .EXPO_CYCLES (EXPO_CYCLES),
        .PHASE_OFFSET(PHASE_OFFSET),
        .DUTY_CFG    (DUTY_CFG),
        .READOUT_ACK (READOUT_ACK),
        .DRAIN_B     (DRAIN_B),
        .PHASE_SEL   (PHASE_SEL),
        .DUTY_SEL    (DUTY_SEL),
        .EXPOSING    (EXPOSING),
        .READOUT_REQ (READOUT_REQ),
        .PHASE_IDX   (PHASE_IDX),
        .BUSY        (BUSY),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 CLK_IN = ~CLK_IN;

    localparam int NPH   = 4;
    localparam int STEP  = 8;
    localparam int DLEN  = 16;
    localparam int TMO   = 4000;

    typedef struct {
        int idx;
        int sel;
        int duty;
        int drain;
        int expo;
    } ph_t;

    ph_t exp_q[$];
    int  done_q[$];
    int  total = 0;
    int  bad = 0;
    int  frame_no = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return READOUT_REQ;
            1: return EXPOSING;
            2: return FRAME_DONE;
            default: return BUSY;
        endcase
    endfunction

    task automatic wait_sig(input int k, input logic lvl, input string nm);
        int n = 0;
        while (sig(k) !== lvl && n < TMO) begin
            @(negedge CLK_IN);
            n++;
        end
        if (n >= TMO) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got no event expected level %0d", nm, lvl);
        end
    endtask

    // Monitor: measures each phase and pops the scoreboard on REQ rise / FRAME_DONE.
    int   drain_run = 0;
    int   expo_run = 0;
    int   seen = 0;
    logic prev_req = 1'b0;
    logic prev_done = 1'b0;
    logic [4:0] prev_sel = '0;
    logic [3:0] prev_duty = '0;
    always @(negedge CLK_IN) begin
        if (!BUSY) begin
            drain_run = 0;
            expo_run = 0;
            seen = 0;
        end else begin
            if (!DRAIN_B && !FRAME_DONE) drain_run++;
            if (EXPOSING) expo_run++;
        end
        if (EXPOSING) chk("expose_drain_b", int'(DRAIN_B), 1);
        if (READOUT_REQ) begin
            chk("req_drain_b", int'(DRAIN_B), 1);
            chk("req_exposing", int'(EXPOSING), 0);
        end
        if (PHASE_SEL != prev_sel) chk("sel_change_drain_b", int'(DRAIN_B), 0);
        if (DUTY_SEL != prev_duty) chk("duty_change_drain_b", int'(DRAIN_B), 0);
        if (READOUT_REQ && !prev_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got idx %0d expected none", PHASE_IDX);
            end else begin
                ph_t e;
                e = exp_q.pop_front();
                chk("phase_idx", int'(PHASE_IDX), e.idx);
                chk("phase_sel", int'(PHASE_SEL), e.sel);
                chk("duty_sel", int'(DUTY_SEL), e.duty);
                chk("drain_len", drain_run, e.drain);
                chk("expose_len", expo_run, e.expo);
            end
            drain_run = 0;
            expo_run = 0;
            seen++;
        end
        if (FRAME_DONE) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got pulse expected none at %0t", $time);
            end else begin
                void'(done_q.pop_front());
                chk("done_phases", seen, NPH);
                chk("done_single", int'(prev_done), 0);
                chk("done_busy", int'(BUSY), 1);
            end
        end
        prev_req = READOUT_REQ;
        prev_done = FRAME_DONE;
        prev_sel = PHASE_SEL;
        prev_duty = DUTY_SEL;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drain_b"}, int'(DRAIN_B), 0);
        chk({tag, "_sel"}, int'(PHASE_SEL), 0);
        chk({tag, "_duty"}, int'(DUTY_SEL), 0);
        chk({tag, "_idx"}, int'(PHASE_IDX), 0);
        chk({tag, "_exposing"}, int'(EXPOSING), 0);
        chk({tag, "_req"}, int'(READOUT_REQ), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_done"}, int'(FRAME_DONE), 0);
    endtask

    // Runs one frame; abort_ph / rst_ph < 0 disable those interruptions.
    task automatic run_frame(input int e, input int off, input int duty,
                             input int ack_dly, input bit early,
                             input int abort_ph, input int rst_ph,
                             input bit start_at_done);
        int nexp;
        int eff;
        eff = (e == 0) ? 1 : e;
        nexp = NPH;
        if (abort_ph >= 0) nexp = abort_ph;
        if (rst_ph >= 0) nexp = rst_ph + 1;
        for (int i = 0; i < nexp; i++) begin
            ph_t p;
            p.idx = i;
            p.sel = (off + i * STEP) % 32;
            p.duty = duty;
            p.drain = DLEN;
            p.expo = 32 * eff;
            exp_q.push_back(p);
        end
        if (abort_ph < 0 && rst_ph < 0) done_q.push_back(frame_no);
        frame_no++;

        EXPO_CYCLES = 16'(e);
        PHASE_OFFSET = 5'(off);
        DUTY_CFG = 4'(duty);
        START = 1'b1;
        @(negedge CLK_IN);
        START = 1'b0;
        EXPO_CYCLES = 16'($urandom_range(0, 7));
        PHASE_OFFSET = 5'($urandom);
        DUTY_CFG = 4'($urandom);
        chk("busy_after_start", int'(BUSY), 1);

        for (int ph = 0; ph < NPH; ph++) begin
            if (ph == abort_ph) begin
                wait_sig(1, 1'b1, "abort_expose");
                repeat (5) @(negedge CLK_IN);
                chk("abort_phase_idx", int'(PHASE_IDX), ph);
                ABORT = 1'b1;
                START = 1'b1;
                @(negedge CLK_IN);
                ABORT = 1'b0;
                START = 1'b0;
                chk("abort_drain_b", int'(DRAIN_B), 0);
                chk("abort_busy", int'(BUSY), 0);
                chk("abort_exposing", int'(EXPOSING), 0);
                chk("abort_req", int'(READOUT_REQ), 0);
                chk("abort_done", int'(FRAME_DONE), 0);
                repeat (3) @(negedge CLK_IN);
                chk("abort_stays_idle", int'(BUSY), 0);
                return;
            end
            if (early) begin
                wait_sig(1, 1'b1, "early_expose");
                READOUT_ACK = 1'b1;
                @(negedge CLK_IN);
                READOUT_ACK = 1'b0;
            end
            wait_sig(0, 1'b1, "req");
            if (ph == rst_ph) begin
                repeat (2) @(negedge CLK_IN);
                #3 RESET_B = 1'b0;
                #1 chk_reset_vals("midrst");
                @(negedge CLK_IN);
                RESET_B = 1'b1;
                @(negedge CLK_IN);
                return;
            end
            repeat (ack_dly) @(negedge CLK_IN);
            chk("req_held", int'(READOUT_REQ), 1);
            READOUT_ACK = 1'b1;
            @(negedge CLK_IN);
            READOUT_ACK = 1'b0;
            chk("req_drop", int'(READOUT_REQ), 0);
        end

        wait_sig(2, 1'b1, "frame_done");
        if (start_at_done) START = 1'b1;
        @(negedge CLK_IN);
        START = 1'b0;
        chk("idle_after_done", int'(BUSY), 0);
        chk("done_cleared", int'(FRAME_DONE), 0);
        @(negedge CLK_IN);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK_IN);
        chk_reset_vals("reset");
        RESET_B = 1'b1;
        @(negedge CLK_IN);
        chk("idle_busy", int'(BUSY), 0);

        run_frame(2, 0, 7, 3, 1'b0, -1, -1, 1'b0);
        run_frame(2, 28, 5, 1, 1'b0, -1, -1, 1'b1);
        run_frame(0, 13, 2, 0, 1'b0, -1, -1, 1'b0);
        run_frame(1, 6, 9, 100, 1'b1, -1, -1, 1'b0);
        run_frame(1, 3, 4, 2, 1'b0, 2, -1, 1'b0);
        run_frame(1, 17, 11, 2, 1'b0, -1, 1, 1'b0);
        run_frame(1, 9, 3, 1, 1'b0, -1, -1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_frame($urandom_range(0, 3), $urandom_range(0, 31),
                      $urandom_range(0, 15), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)), -1, -1,
                      1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CLK_IN);
        chk("phases_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
